// File: rtl/dma_pkg.sv
// Shared types and constants for the bus DMA engine.
//   dma_mode_t  : transfer kind (copy or constant fill)
//   dma_state_t : controller states
//   WORD_BYTES  : byte stride between consecutive words
//   FULL_MASK   : byte mask presented with every write
//   word_align  : clears the sub-word address bits
package dma_pkg;

  // Prefixes keep the FILL mode and the FILL state from colliding in one scope.
  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } dma_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FILL
  } dma_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] FULL_MASK  = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Simple on-chip memory bus with independent read and write ports.
//   raddr/ren    : read request, data returned on rdata one cycle later
//   waddr/wen    : write request with wdata and per-byte bytemask
//   master       : initiator view (drives requests, consumes rdata)
//   slave        : target view (consumes requests, drives rdata)
interface bus_if;
  logic [31:0] raddr;
  logic [31:0] waddr;
  logic        ren;
  logic        wen;
  logic [3:0]  bytemask;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output raddr, waddr, ren, wen, bytemask, wdata,
    input  rdata
  );

  modport slave (
    input  raddr, waddr, ren, wen, bytemask, wdata,
    output rdata
  );
endinterface

// File: rtl/bus_dma.sv
// Bus DMA engine: copies a block of 32-bit words between byte addresses,
// or fills a block with a constant word. Copy streams one word per cycle by
// overlapping the read of word i+1 with the write of word i.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request pulse, sampled only while idle
//   mode        : 0 = copy, 1 = fill
//   src, dst    : byte addresses (bits [1:0] ignored)
//   len         : transfer length in words (0 completes immediately)
//   fill_value  : word written in fill mode
//   abort       : cancel an active transfer, no done pulse
//   busy        : transfer in progress
//   done        : one-cycle pulse on normal completion
//   bus         : bus_if master port
module bus_dma
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          src,
  input  logic [31:0]          dst,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [31:0]          fill_value,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  bus_if.master                bus
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  dma_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;      // words still to issue after the current one
  logic [31:0]          raddr_q, raddr_d;
  logic [31:0]          waddr_q, waddr_d;
  logic [31:0]          wdata_q, wdata_d;  // fill word
  logic                 ren_q, ren_d;
  logic                 wen_q, wen_d;
  logic [3:0]           bytemask_q, bytemask_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;    // copy write: data comes straight from rdata

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    pass_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else if (dma_mode_t'(mode) == MODE_FILL) begin
            state_d = S_FILL;
            wen_d   = 1'b1;
            waddr_d = word_align(dst);
            wdata_d = fill_value;
            cnt_d   = len - LEN_WIDTH'(1);
          end else begin
            state_d = S_READ;
            ren_d   = 1'b1;
            raddr_d = word_align(src);
            // Pre-decremented so the first write cycle advances onto dst.
            waddr_d = word_align(dst) - STEP;
            cnt_d   = len - LEN_WIDTH'(1);
          end
        end
      end

      S_READ: begin
        // Each cycle in READ retires the read issued this cycle as a write next cycle.
        wen_d   = 1'b1;
        pass_d  = 1'b1;
        waddr_d = waddr_q + STEP;
        if (cnt_q != '0) begin
          ren_d   = 1'b1;
          raddr_d = raddr_q + STEP;
          cnt_d   = cnt_q - LEN_WIDTH'(1);
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      S_FILL: begin
        if (cnt_q != '0) begin
          wen_d   = 1'b1;
          waddr_d = waddr_q + STEP;
          cnt_d   = cnt_q - LEN_WIDTH'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort drops everything not yet presented; a read already on the bus
    // returns data that is simply never written.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      pass_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d     = (state_d != S_IDLE);
    bytemask_d = wen_d ? FULL_MASK : 4'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      bytemask_q <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      bytemask_q <= bytemask_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.raddr    = raddr_q;
  assign bus.waddr    = waddr_q;
  assign bus.ren      = ren_q;
  assign bus.wen      = wen_q;
  assign bus.bytemask = bytemask_q;
  // The slave returns read data one cycle after the request; forwarding it
  // directly lets the write land in that same cycle and keeps copy at one
  // word per cycle. The select itself is registered, and rdata is only
  // consumed in the cycle right after a read.
  assign bus.wdata    = pass_q ? bus.rdata : wdata_q;

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: a bench-owned read-before-write RAM on
// the bus, a monitor that pops expected reads/writes from scoreboard queues,
// and directed steps checking cycle timing and final memory contents.
module tb_bus_dma;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int done_cyc, done_cnt;
    int busy_first, busy_last;
    int ren_first, ren_last, ren_cnt;
    int wen_first, wen_last, wen_cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic [31:0] fill_value = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;

  // restart parameters used by observe()
  logic        r_mode = 1'b0;
  logic [31:0] r_src = '0, r_dst = '0, r_fill = '0;
  logic [15:0] r_len = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rq[$];
  wr_t         wq[$];

  bus_if bus ();

  bus_dma #(.LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- bench RAM (1 KiB, read-before-write) ----------------
  logic [31:0] mem [0:255];
  logic        init_mem = 1'b0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  function automatic logic [31:0] pattern(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (init_mem)
      for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
    if (pre_we) mem[pre_idx] <= pre_val;
    if (bus.ren) bus.rdata <= mem[bus.raddr[9:2]];
    if (bus.wen)
      for (int b = 0; b < 4; b++)
        if (bus.bytemask[b]) mem[bus.waddr[9:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every bus request must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("bytemask", 32'(bus.bytemask), bus.wen ? 32'hF : 32'h0);
      if (bus.ren) begin
        if (rq.size() == 0) check("unexpected_read", bus.raddr, 32'hFFFF_FFFF);
        else check("raddr", bus.raddr, rq.pop_front());
      end
      if (bus.wen) begin
        if (wq.size() == 0) begin
          check("unexpected_write", bus.waddr, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("waddr", bus.waddr, w.a);
          check("wdata", bus.wdata, w.d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ram_poke(input logic [7:0] idx, input logic [31:0] v);
    pre_idx = idx;
    pre_val = v;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
  endtask

  // Called just after a clock edge: this is cycle 0, the next cycle is cycle 1.
  task automatic pulse_start(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] l, input logic [31:0] f);
    mode = m; src = s; dst = d; len = l; fill_value = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] words[4], input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) rq.push_back(s + 32'(4 * i));
    for (int i = 0; i < n_wr; i++) wq.push_back('{a: d + 32'(4 * i), d: words[i]});
  endtask

  // Watches cycles 1..max_c; optional abort and restart pulses at given cycles.
  task automatic observe(input int max_c, input int abort_at, input int ra, input int rb,
                         output obs_t o);
    bool_loop: begin end
    o = '{done_cyc: -1, done_cnt: 0, busy_first: -1, busy_last: -1,
          ren_first: -1, ren_last: -1, ren_cnt: 0,
          wen_first: -1, wen_last: -1, wen_cnt: 0};
    for (int c = 1; c <= max_c; c++) begin
      logic saw_done;
      @(negedge clk);
      saw_done = done;
      if (busy) begin if (o.busy_first < 0) o.busy_first = c; o.busy_last = c; end
      if (bus.ren) begin if (o.ren_first < 0) o.ren_first = c; o.ren_last = c; o.ren_cnt++; end
      if (bus.wen) begin if (o.wen_first < 0) o.wen_first = c; o.wen_last = c; o.wen_cnt++; end
      if (saw_done) begin if (o.done_cyc < 0) o.done_cyc = c; o.done_cnt++; end
      if (c == abort_at) abort = 1'b1;
      if (c == ra || c == rb) begin
        mode = r_mode; src = r_src; dst = r_dst; len = r_len; fill_value = r_fill;
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (saw_done) break;
    end
  endtask

  task automatic check_obs(input string t, input obs_t o, input int done_c, input int busy_f,
                           input int busy_l, input int ren_n, input int ren_f, input int ren_l,
                           input int wen_n, input int wen_f, input int wen_l);
    check({t, "_done_cycle"}, o.done_cyc, done_c);
    check({t, "_done_count"}, o.done_cnt, (done_c < 0) ? 0 : 1);
    check({t, "_busy_first"}, o.busy_first, busy_f);
    check({t, "_busy_last"},  o.busy_last,  busy_l);
    check({t, "_ren_count"},  o.ren_cnt,    ren_n);
    check({t, "_ren_first"},  o.ren_first,  ren_f);
    check({t, "_ren_last"},   o.ren_last,   ren_l);
    check({t, "_wen_count"},  o.wen_cnt,    wen_n);
    check({t, "_wen_first"},  o.wen_first,  wen_f);
    check({t, "_wen_last"},   o.wen_last,   wen_l);
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_ren"},      32'(bus.ren),      0);
    check({t, "_wen"},      32'(bus.wen),      0);
    check({t, "_raddr"},    bus.raddr,         0);
    check({t, "_waddr"},    bus.waddr,         0);
    check({t, "_wdata"},    bus.wdata,         0);
    check({t, "_bytemask"}, 32'(bus.bytemask), 0);
    check({t, "_busy"},     32'(busy),         0);
    check({t, "_done"},     32'(done),         0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    obs_t        o;
    logic [31:0] words[4];
    words = '{32'h11, 32'h22, 32'h33, 32'h44};

    // Reset state and RAM preload.
    @(posedge clk); #1;
    check_reset_outputs("reset");
    init_mem = 1'b1;
    @(posedge clk); #1;
    init_mem = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ram_poke(8'(8'h40 + i), words[i]);

    // Copy 4 words 0x100 -> 0x200.
    push_copy(32'h100, 32'h200, words, 4, 4);
    pulse_start(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
    observe(12, 0, 0, 0, o);
    check_obs("copy4", o, 6, 1, 5, 4, 1, 4, 4, 2, 5);
    for (int i = 0; i < 4; i++) check("copy4_mem", mem[8'h80 + i], words[i]);

    // Fill 3 words at 0x40 (low address bits set to confirm they are dropped).
    for (int i = 0; i < 3; i++) wq.push_back('{a: 32'h40 + 32'(4 * i), d: 32'hDEADBEEF});
    pulse_start(1'b1, 32'h0, 32'h43, 16'd3, 32'hDEADBEEF);
    observe(10, 0, 0, 0, o);
    check_obs("fill3", o, 4, 1, 3, 0, -1, -1, 3, 1, 3);
    for (int i = 0; i < 3; i++) check("fill3_mem", mem[8'h10 + i], 32'hDEADBEEF);
    check("fill3_mem_after", mem[8'h13], pattern(8'h13));

    // Zero-length copy and fill.
    pulse_start(1'b0, 32'h100, 32'h200, 16'd0, 32'h0);
    observe(5, 0, 0, 0, o);
    check_obs("copy0", o, 1, -1, -1, 0, -1, -1, 0, -1, -1);
    pulse_start(1'b1, 32'h100, 32'h200, 16'd0, 32'h5555_5555);
    observe(5, 0, 0, 0, o);
    check_obs("fill0", o, 1, -1, -1, 0, -1, -1, 0, -1, -1);

    // Copy 8 words to 0x280, aborted in cycle 3.
    push_copy(32'h100, 32'h280, words, 3, 2);
    pulse_start(1'b0, 32'h100, 32'h280, 16'd8, 32'h0);
    observe(12, 3, 0, 0, o);
    check_obs("abort", o, -1, 1, 3, 3, 1, 3, 2, 2, 3);
    check("abort_mem0", mem[8'hA0], 32'h11);
    check("abort_mem1", mem[8'hA1], 32'h22);
    check("abort_mem2", mem[8'hA2], pattern(8'hA2));
    check("abort_mem7", mem[8'hA7], pattern(8'hA7));

    // Copy to 0x300 with a start in cycle 2 (ignored, inputs changed too) and
    // a start in the done cycle (accepted): fill 2 words at 0x380.
    push_copy(32'h100, 32'h300, words, 4, 4);
    wq.push_back('{a: 32'h380, d: 32'hCAFEF00D});
    wq.push_back('{a: 32'h384, d: 32'hCAFEF00D});
    r_mode = 1'b1; r_src = 32'h0; r_dst = 32'h380; r_len = 16'd2; r_fill = 32'hCAFEF00D;
    pulse_start(1'b0, 32'h100, 32'h300, 16'd4, 32'h0);
    observe(12, 0, 2, 6, o);
    check_obs("busy_start", o, 6, 1, 5, 4, 1, 4, 4, 2, 5);
    observe(10, 0, 0, 0, o);
    check_obs("b2b_fill", o, 3, 1, 2, 0, -1, -1, 2, 1, 2);
    for (int i = 0; i < 4; i++) check("busy_start_mem", mem[8'hC0 + i], words[i]);
    check("b2b_mem0", mem[8'hE0], 32'hCAFEF00D);
    check("b2b_mem1", mem[8'hE1], 32'hCAFEF00D);
    check("b2b_mem2", mem[8'hE2], pattern(8'hE2));

    // Reset asserted in cycle 2 of a copy to 0x3C0.
    rq.push_back(32'h100);
    pulse_start(1'b0, 32'h100, 32'h3C0, 16'd4, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem", mem[8'hF0], pattern(8'hF0));
    push_copy(32'h100, 32'h3C0, words, 2, 2);
    pulse_start(1'b0, 32'h100, 32'h3C0, 16'd2, 32'h0);
    observe(10, 0, 0, 0, o);
    check_obs("after_rst", o, 4, 1, 3, 2, 1, 2, 2, 2, 3);
    check("after_rst_mem0", mem[8'hF0], 32'h11);
    check("after_rst_mem1", mem[8'hF1], 32'h22);
    check("after_rst_mem2", mem[8'hF2], pattern(8'hF2));

    // Abort while idle has no effect.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 0);
    check("idle_abort_done", 32'(done), 0);

    check("read_queue_empty",  rq.size(), 0);
    check("write_queue_empty", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
